// File: rtl/id_stage_hz.sv
// RV32I decode stage: register file with optional write-back bypass, immediate and
// control decode, load-use stall, redirect flush, and an ID/EX pipeline register.
module id_stage_hz #(
   parameter int XLEN      = 32,
   parameter int NREG      = 32,
   parameter int RF_BYPASS = 1,
   localparam int AW       = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] pc_4,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            id_stall,
   output logic            ex_valid,
   output logic [XLEN-1:0] read1,
   output logic [XLEN-1:0] read2,
   output logic [XLEN-1:0] imm_out,
   output logic [AW-1:0]   rd_out,
   output logic [6:0]      opcode,
   output logic [2:0]      func3,
   output logic [3:0]      alu_ctrl,
   output logic            su,
   output logic [1:0]      whb,
   output logic [1:0]      wos,
   output logic [XLEN-1:0] pc_id,
   output logic [XLEN-1:0] pc_4_id
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Handshake: if_valid qualifies instr/pc/pc_4 every cycle. id_stall high means
   // ID did not accept the word and IF must present it again next cycle; ex_valid
   // marks the ID/EX register as holding a live instruction for EX.

   logic [XLEN-1:0] r_rf [NREG];

   logic            r_ex_valid;
   logic [XLEN-1:0] r_read1;
   logic [XLEN-1:0] r_read2;
   logic [XLEN-1:0] r_imm;
   logic [AW-1:0]   r_rd;
   logic [6:0]      r_opcode;
   logic [2:0]      r_func3;
   logic [3:0]      r_alu_ctrl;
   logic            r_su;
   logic [1:0]      r_whb;
   logic [1:0]      r_wos;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_pc_4;

   logic [6:0]      w_op;
   logic [2:0]      w_f3;
   logic [AW-1:0]   w_rs1;
   logic [AW-1:0]   w_rs2;
   logic [AW-1:0]   w_rd;
   logic [XLEN-1:0] w_read1;
   logic [XLEN-1:0] w_read2;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm;
   logic [3:0]      w_alu_ctrl;
   logic            w_su;
   logic [1:0]      w_whb;
   logic [1:0]      w_wos;
   logic            w_rs1_used;
   logic            w_rs2_used;
   logic            w_hazard;
   logic            w_stall;

   assign w_op  = instr[6:0];
   assign w_f3  = instr[14:12];
   assign w_rs1 = instr[15 +: AW];
   assign w_rs2 = instr[20 +: AW];
   assign w_rd  = instr[7 +: AW];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      end else if (wb_en && (wb_rd != '0)) begin
         r_rf[wb_rd] <= wb_data;
      end
   end

   always_comb begin
      w_read1 = '0;
      w_read2 = '0;
      if (w_rs1 != '0) begin
         if ((RF_BYPASS != 0) && wb_en && (wb_rd == w_rs1)) w_read1 = wb_data;
         else                                               w_read1 = r_rf[w_rs1];
      end
      if (w_rs2 != '0) begin
         if ((RF_BYPASS != 0) && wb_en && (wb_rd == w_rs2)) w_read2 = wb_data;
         else                                               w_read2 = r_rf[w_rs2];
      end
   end

   always_comb begin
      w_imm32    = '0;
      w_alu_ctrl = 4'b0000;
      w_su       = 1'b0;
      w_whb      = 2'b00;
      w_wos      = 2'b00;
      unique case (w_op)
         OP_R: begin
            w_alu_ctrl = {instr[30], w_f3};
         end
         OP_IMM: begin
            w_imm32    = {{20{instr[31]}}, instr[31:20]};
            // Bit 30 only distinguishes SRAI from SRLI; for other OP-IMM it is immediate data.
            w_alu_ctrl = {(w_f3 == 3'b101) ? instr[30] : 1'b0, w_f3};
         end
         OP_LOAD: begin
            w_imm32 = {{20{instr[31]}}, instr[31:20]};
            w_whb   = w_f3[1:0];
            w_su    = ~w_f3[2];
            w_wos   = 2'b01;
         end
         OP_JALR: begin
            w_imm32 = {{20{instr[31]}}, instr[31:20]};
            w_wos   = 2'b10;
         end
         OP_STORE: begin
            w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            w_whb   = w_f3[1:0];
         end
         OP_BRANCH: begin
            w_imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            w_alu_ctrl = {1'b0, w_f3};
         end
         OP_LUI: begin
            w_imm32 = {instr[31:12], 12'b0};
            w_wos   = 2'b11;
         end
         OP_AUIPC: begin
            w_imm32 = {instr[31:12], 12'b0};
         end
         OP_JAL: begin
            w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            w_wos   = 2'b10;
         end
         default: ;
      endcase
   end

   assign w_imm = XLEN'($signed(w_imm32));

   assign w_rs1_used = !((w_op == OP_LUI) || (w_op == OP_AUIPC) || (w_op == OP_JAL));
   assign w_rs2_used = (w_op == OP_R) || (w_op == OP_STORE) || (w_op == OP_BRANCH);

   // A load in EX has no data yet; its consumer in ID waits one cycle and then
   // picks the value up through the write-back bypass or the register file.
   assign w_hazard = if_valid && r_ex_valid && (r_opcode == OP_LOAD) && (r_rd != '0) &&
                     ((w_rs1_used && (w_rs1 == r_rd)) || (w_rs2_used && (w_rs2 == r_rd)));
   assign w_stall  = w_hazard && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ex_valid <= 1'b0;
         r_read1    <= '0;
         r_read2    <= '0;
         r_imm      <= '0;
         r_rd       <= '0;
         r_opcode   <= '0;
         r_func3    <= '0;
         r_alu_ctrl <= '0;
         r_su       <= 1'b0;
         r_whb      <= '0;
         r_wos      <= '0;
         r_pc       <= '0;
         r_pc_4     <= '0;
      end else begin
         r_ex_valid <= if_valid && !flush && !w_stall;
         // Fields hold through a bubble; ex_valid alone marks it dead.
         if (!w_stall) begin
            r_read1    <= w_read1;
            r_read2    <= w_read2;
            r_imm      <= w_imm;
            r_rd       <= w_rd;
            r_opcode   <= w_op;
            r_func3    <= w_f3;
            r_alu_ctrl <= w_alu_ctrl;
            r_su       <= w_su;
            r_whb      <= w_whb;
            r_wos      <= w_wos;
            r_pc       <= pc;
            r_pc_4     <= pc_4;
         end
      end
   end

   assign id_stall = w_stall;
   assign ex_valid = r_ex_valid;
   assign read1    = r_read1;
   assign read2    = r_read2;
   assign imm_out  = r_imm;
   assign rd_out   = r_rd;
   assign opcode   = r_opcode;
   assign func3    = r_func3;
   assign alu_ctrl = r_alu_ctrl;
   assign su       = r_su;
   assign whb      = r_whb;
   assign wos      = r_wos;
   assign pc_id    = r_pc;
   assign pc_4_id  = r_pc_4;

endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
- Parametrised successor to the pipelined ID stage.
- Decodes one RV32I instruction per cycle and reads the internal register file, with an optional write-back bypass.
- Registers all results into an ID/EX pipeline register.
- Adds what the earlier stage lacked: load-use hazard detection with a one-cycle stall, branch-redirect flush, and valid tracking.
- Sits between IF and EX.

Parameters:
- XLEN, 32, datapath width (32 or 64); immediates sign-extend to XLEN.
- NREG, 32, number of architectural registers (power of 2, 2..32); AW = log2(NREG).
- RF_BYPASS, 1, 1 = a same-cycle write-back is visible to the decode read; 0 = the next cycle sees it.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- if_valid  in  1  instr/pc/pc_4 valid from IF
- instr  in  32  instruction word
- pc  in  XLEN  instruction PC
- pc_4  in  XLEN  PC+4
- wb_en  in  1  register write enable from WB
- wb_rd  in  AW  write-back destination
- wb_data  in  XLEN  write-back data
- flush  in  1  branch/jump redirect from EX; kill the instruction in ID
- id_stall  out  1  combinational; IF holds PC and instr
- ex_valid  out  1  ID/EX register holds a live instruction
- read1, read2  out  XLEN  operand values
- imm_out  out  XLEN  sign-extended immediate
- rd_out  out  AW  destination register
- opcode  out  7  instr[6:0]
- func3  out  3  instr[14:12]
- alu_ctrl  out  4  ALU operation
- su  out  1  load sign control (1 = signed)
- whb  out  2  memory size: 00 byte, 01 half, 10 word
- wos  out  2  write-back select: 00 ALU, 01 memory, 10 PC+4, 11 imm
- pc_id, pc_4_id  out  XLEN  forwarded PCs

Behaviour:
- Reset: rst low clears every registered output and all register-file entries to 0 immediately. While ex_valid=0, id_stall=0.
- Register file:
  - Write occurs on the rising edge when wb_en=1 and wb_rd != 0.
  - x0 always reads 0.
  - Reads are combinational on rs1 = instr[19:15] and rs2 = instr[24:20], truncated to AW.
  - RF_BYPASS=1: if wb_en=1, wb_rd == rs, and rs != 0, the read returns wb_data.
- Decode latency: 1 cycle. ID/EX register loads on each edge unless overridden by the priority rules below.
- Immediates, by opcode:
  - I-type (0010011, 0000011, 1100111): instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type: {instr[31:12], 12'b0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All sign-extended to XLEN; others 0.
- alu_ctrl:
  - R-type: {instr[30], func3}.
  - OP-IMM: {instr[30] only when func3 = 101, else 0, func3}.
  - Branch: {0, func3}.
  - Otherwise: 0000 (add).
- Loads: whb = func3[1:0], su = ~func3[2], wos = 01.
- Stores: whb = func3[1:0], su = 0.
- wos for other opcodes: JAL/JALR = 10, LUI = 11, all others 00.
- Register usage for hazard checks:
  - rs1 is used by all opcodes except LUI, AUIPC, JAL.
  - rs2 is used by R, S, B only.
- Load-use hazard: id_stall = if_valid & ex_valid & (opcode == 0000011) & (rd_out != 0) & ((rs1 used & rs1 == rd_out) | (rs2 used & rs2 == rd_out)).
  - On stall, the ID/EX register loads a bubble: ex_valid=0, other fields don't-care.
  - IF holds, so the instruction re-decodes next cycle with the hazard resolved. The stall lasts exactly one cycle.
- Priority on a clock edge:
  1. flush: ex_valid <= 0; id_stall is forced to 0 that cycle.
  2. id_stall: bubble.
  3. Otherwise: ex_valid <= if_valid, all fields load.
- Reset mid-stall: outputs clear; IF restarts.
- A simultaneous write-back to a stalled source is captured by the bypass on the retry cycle.

Test Plan:
- Write x6 = 100 via WB, then instr = 32'h100302e7, pc = 0xC, pc_4 = 0x10 -> next edge: ex_valid=1, read1=100, imm_out=256, rd_out=5, opcode=1100111, wos=10, pc_4_id=0x10.
- RF_BYPASS=1: wb_en=1, wb_rd=6, wb_data=0xABCD in the same cycle as add x7,x6,x6 -> read1 = read2 = 0xABCD. Repeat with RF_BYPASS=0 -> previous value.
- lw x5,0(x1) followed by add x7,x5,x2 -> id_stall=1 for one cycle, ex_valid=0 bubble, then add issues with alu_ctrl=0000.
- lw x0 followed by add using x0 -> no stall. lw x5 followed by lui x5 -> no stall.
- flush asserted during the load-use stall -> id_stall=0, ex_valid=0 next cycle.
- Assert rst low mid-stream -> all outputs and x1..x(NREG-1) read 0 immediately. Writes to x0 are ignored.
